// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, FSM state encodings and next-PC selects shared by the multicycle controller
package multicycle_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLTZ = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_LS = 4'd3,
    S_EXE_BR = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;
  function automatic logic br_taken(logic [5:0] op, logic zero, logic sign);
    return (op == OP_BEQ && zero) || (op == OP_BNE && !zero) || (op == OP_BLTZ && sign);
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: datapath-to-controller status and controller strobes
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] Op;
  logic ZERO;
  logic SIGN;
  logic mem_ready;
  logic PCWre;
  logic IRWre;
  logic RegWr;
  logic nRD;
  logic nWR;
  logic [1:0] PCSel;
  logic [3:0] state;
  logic halted;
  logic fault;
  logic [CNT_W-1:0] retired;
  modport master (
    input  Op, ZERO, SIGN, mem_ready,
    output PCWre, IRWre, RegWr, nRD, nWR, PCSel, state, halted, fault, retired
  );
  modport slave (
    output Op, ZERO, SIGN, mem_ready,
    input  PCWre, IRWre, RegWr, nRD, nWR, PCSel, state, halted, fault, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB sequencer owning every state-changing strobe of the datapath
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input logic clk,
  input logic RST,
  multicycle_ctrl_if.master bus
);
  localparam int WC_W = $clog2(WAIT_MAX + 1);
  state_t state, state_nx;
  logic [WC_W-1:0] wcnt, wcnt_nx;
  logic fault, fault_nx, retire;
  logic [CNT_W-1:0] retired;
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= S_IF;
      wcnt    <= '0;
      fault   <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      fault   <= fault_nx;
      retired <= retired + CNT_W'(retire);
    end
  end
  // retire marks exactly the cycles that issue a completing PC load
  always_comb begin
    state_nx = S_IF;
    wcnt_nx  = wcnt;
    fault_nx = fault;
    retire   = 1'b0;
    case (state)
      S_IF:     state_nx = S_ID;
      S_ID:
        case (bus.Op)
          OP_HALT:                  state_nx = S_HALT;
          OP_R, OP_ADDI, OP_ORI:    state_nx = S_EXE_AL;
          OP_LW, OP_SW:             state_nx = S_EXE_LS;
          OP_BEQ, OP_BNE, OP_BLTZ:  state_nx = S_EXE_BR;
          default:                  retire   = 1'b1;
        endcase
      S_EXE_AL: state_nx = S_WB_AL;
      S_EXE_LS: begin
        state_nx = S_MEM;
        wcnt_nx  = '0;
      end
      S_EXE_BR: retire = 1'b1;
      S_MEM:
        if (bus.mem_ready) begin
          state_nx = bus.Op == OP_LW ? S_WB_LD : S_IF;
          retire   = bus.Op != OP_LW;
        end else if (wcnt == WC_W'(WAIT_MAX - 1)) begin
          state_nx = S_HALT;
          fault_nx = 1'b1;
        end else begin
          state_nx = S_MEM;
          wcnt_nx  = wcnt + 1'b1;
        end
      S_WB_AL, S_WB_LD: retire = 1'b1;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IF;
    endcase
  end
  always_comb begin
    bus.PCWre   = retire;
    bus.IRWre   = state == S_IF;
    bus.RegWr   = state == S_WB_AL || state == S_WB_LD;
    bus.nRD     = !(state == S_MEM && bus.Op == OP_LW);
    bus.nWR     = !(state == S_MEM && bus.Op == OP_SW);
    bus.PCSel   = state == S_ID && bus.Op == OP_J ? PC_JMP :
                  state == S_EXE_BR && br_taken(bus.Op, bus.ZERO, bus.SIGN) ? PC_BR : PC_SEQ;
    bus.state   = state;
    bus.halted  = state == S_HALT;
    bus.fault   = fault;
    bus.retired = retired;
  end
endmodule
